if_pc_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline: holds the program counter, drives the instruction-memory address, and produces PC+4 for the next-PC selection mux.
- Takes the selected next PC back from that mux and registers the fetched instruction into the IF/ID pipeline register.
- Sequenced by the debug unit in two modes: free run and single step.
- Freezes on the HALT word.

---
 rtl/mips_pkg.sv | 12 +
 rtl/if_pc_stage.sv | 81 ++++++++
 tb/tb_if_pc_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the fetch stage (FSM encoding, PC increment, halt word, IF/ID bubble).
package mips_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_STEP_WAIT = 3'd2;
  localparam logic [2:0] ST_STEP_EXEC = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;
  localparam int PC_INCR = 4;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic BUBBLE_VALID = 1'b0;
endpackage

// File: rtl/if_pc_stage.sv
// if_pc_stage: MIPS fetch stage holding the PC and IF/ID register, sequenced by the debug unit.
module if_pc_stage
  import mips_pkg::*;
#(
  parameter int len = 32,
  parameter logic [len-1:0] pc_reset = '0,
  parameter logic [len-1:0] halt_word = len'(HALT_WORD)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [len-1:0] i_next_pc,
  input  logic           i_stall,
  input  logic           i_flush,
  input  logic           i_start,
  input  logic           i_step_mode,
  input  logic           i_step,
  input  logic [len-1:0] i_imem_data,
  output logic [len-1:0] o_imem_addr,
  output logic           o_imem_en,
  output logic [len-1:0] o_pc_plus4,
  output logic [len-1:0] o_if_id_instr,
  output logic [len-1:0] o_if_id_pc_plus4,
  output logic           o_if_id_valid,
  output logic           o_halted,
  output logic [len-1:0] o_cycle_count
);
  logic [2:0] state_q, state_d;
  logic [len-1:0] pc_q, pc_d, instr_q, instr_d, pp4_q, pp4_d, cnt_q, cnt_d;
  logic valid_q, valid_d, step_prev_q;
  logic active, adv, halt_hit, step_rise, bubble;
  assign active = state_q == ST_RUN || state_q == ST_STEP_EXEC;
  assign adv = active && !i_flush && !i_stall;
  assign halt_hit = adv && i_imem_data == halt_word;
  // A held i_step only counts once: stepping triggers on its rising edge.
  assign step_rise = i_step && !step_prev_q;
  assign bubble = (active && i_flush) || state_q == ST_HALTED;
  assign o_pc_plus4 = pc_q + len'(PC_INCR);
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = i_start ? (i_step_mode ? ST_STEP_WAIT : ST_RUN) : ST_IDLE;
      ST_RUN:       state_d = halt_hit ? ST_HALTED : ST_RUN;
      ST_STEP_WAIT: state_d = step_rise ? ST_STEP_EXEC : ST_STEP_WAIT;
      ST_STEP_EXEC: state_d = halt_hit ? ST_HALTED : ST_STEP_WAIT;
      default:      state_d = ST_HALTED;
    endcase
  end
  always_comb begin
    pc_d    = (adv || (active && i_flush)) ? i_next_pc : pc_q;
    instr_d = bubble ? len'(BUBBLE_INSTR) : adv ? i_imem_data : instr_q;
    pp4_d   = bubble ? '0 : adv ? o_pc_plus4 : pp4_q;
    valid_d = bubble ? BUBBLE_VALID : adv ? 1'b1 : valid_q;
    cnt_d   = active ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= pc_reset;
      instr_q     <= '0;
      pp4_q       <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pp4_q       <= pp4_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      step_prev_q <= i_step;
    end
  end
  assign o_imem_addr      = pc_q;
  assign o_imem_en        = active;
  assign o_if_id_instr    = instr_q;
  assign o_if_id_pc_plus4 = pp4_q;
  assign o_if_id_valid    = valid_q;
  assign o_halted         = state_q == ST_HALTED;
  assign o_cycle_count    = cnt_q;
endmodule

// File: tb/tb_if_pc_stage.sv
// tb_if_pc_stage: randomized and directed checks of if_pc_stage against a behavioural fetch model.
module tb_if_pc_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall, flush, start, step_mode, step, np_ovr, halt_en, w_start;
  logic [31:0] np_val, xmask, halt_addr, next_pc, imem;
  logic [31:0] addr, pp4, instr, ifpp4, cnt;
  logic en, valid, halted;
  logic [31:0] w_addr, w_pp4, w_instr, w_ifpp4, w_cnt, w_imem;
  logic w_en, w_valid, w_halted;
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic m_valid;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign next_pc = np_ovr ? np_val : pp4;
  assign imem = (halt_en && addr == halt_addr) ? 32'hFFFF_FFFF : (addr | 32'h1000) ^ xmask;
  assign w_imem = w_addr | 32'h1000;

  if_pc_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_next_pc(next_pc), .i_stall(stall), .i_flush(flush),
    .i_start(start), .i_step_mode(step_mode), .i_step(step), .i_imem_data(imem),
    .o_imem_addr(addr), .o_imem_en(en), .o_pc_plus4(pp4), .o_if_id_instr(instr),
    .o_if_id_pc_plus4(ifpp4), .o_if_id_valid(valid), .o_halted(halted), .o_cycle_count(cnt)
  );

  if_pc_stage #(.pc_reset(32'hFFFF_FFFC)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_next_pc(w_pp4), .i_stall(1'b0), .i_flush(1'b0),
    .i_start(w_start), .i_step_mode(1'b0), .i_step(1'b0), .i_imem_data(w_imem),
    .o_imem_addr(w_addr), .o_imem_en(w_en), .o_pc_plus4(w_pp4), .o_if_id_instr(w_instr),
    .o_if_id_pc_plus4(w_ifpp4), .o_if_id_valid(w_valid), .o_halted(w_halted), .o_cycle_count(w_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; step = 0; step_mode = 0; stall = 0; flush = 0;
    np_ovr = 0; np_val = 0; xmask = 0; halt_en = 0; halt_addr = 0; w_start = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic go(input logic mode);
    start = 1; step_mode = mode;
    tick();
    start = 0; step_mode = 0;
  endtask

  // One active fetch cycle as the pipeline sees it: flush beats stall beats advance.
  task automatic cyc(input logic s, input logic f, input logic ovr, input logic [31:0] v);
    logic [31:0] np;
    stall = s; flush = f; np_ovr = ovr; np_val = v;
    np = ovr ? v : m_pc + 32'd4;
    m_cnt = m_cnt + 1;
    if (f) begin
      m_pc = np; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = (m_pc | 32'h1000) ^ xmask; m_pp4 = m_pc + 32'd4; m_valid = 1; m_pc = np;
    end
    tick();
    stall = 0; flush = 0; np_ovr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; step = 0; step_mode = 0; stall = 0; flush = 0;
    np_ovr = 0; np_val = 0; xmask = 0; halt_en = 0; halt_addr = 0; w_start = 0;
    tick();
    checks++;
    if ({addr, instr, ifpp4, valid, cnt, en, halted} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ins=%h pp4=%h v=%b cnt=%h en=%b h=%b want all zero",
               addr, instr, ifpp4, valid, cnt, en, halted);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({addr, en, cnt} !== {32'h0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got pc=%h en=%b cnt=%h want pc=0 en=0 cnt=0", i, addr, en, cnt);
      end
    end
  endtask

  task automatic test_run();
    do_reset();
    go(1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if ({instr, ifpp4, valid, en} !== {32'h1000 + 32'(4 * i), 32'(4 * (i + 1)), 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL run_ifid[%0d]: got ins=%h pp4=%h v=%b en=%b want ins=%h pp4=%h v=1 en=1",
                 i, instr, ifpp4, valid, en, 32'h1000 + 32'(4 * i), 32'(4 * (i + 1)));
      end
    end
    checks++;
    if (cnt !== 32'd3) begin
      errors++;
      $display("FAIL run_count: got %0d want 3", cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go(1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    checks++;
    if (addr !== 32'h20) begin
      errors++;
      $display("FAIL pre_reset_pc: got %h want 00000020", addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr, valid, cnt, en} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got pc=%h v=%b cnt=%h en=%b want 0 0 0 0", addr, valid, cnt, en);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({addr, en} !== {32'h0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_hold[%0d]: got pc=%h en=%b want 0 0", i, addr, en);
      end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    go(1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if ({addr, instr, ifpp4, valid, cnt} !== {32'h8, 32'h1004, 32'h8, 1'b1, 32'(3 + i)}) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h ins=%h pp4=%h v=%b cnt=%0d want pc=8 ins=1004 pp4=8 v=1 cnt=%0d",
                 i, addr, instr, ifpp4, valid, cnt, 3 + i);
      end
    end
    cyc(1, 1, 1, 32'h40);
    checks++;
    if ({addr, instr, ifpp4, valid, cnt} !== {32'h40, 32'h0, 32'h0, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL flush_over_stall: got pc=%h ins=%h pp4=%h v=%b cnt=%0d want pc=40 bubble cnt=5",
               addr, instr, ifpp4, valid, cnt);
    end
  endtask

  task automatic test_step();
    do_reset();
    go(1'b1);
    for (int p = 0; p < 3; p++) begin
      step = 1; tick();
      step = 0; tick();
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if ({addr, instr, valid, cnt, en} !== {32'(4 * (p + 1)), 32'h1000 | 32'(4 * p), 1'b1, 32'(p + 1), 1'b0}) begin
        errors++;
        $display("FAIL step_pulse[%0d]: got pc=%h ins=%h v=%b cnt=%0d en=%b want pc=%h cnt=%0d en=0",
                 p, addr, instr, valid, cnt, en, 32'(4 * (p + 1)), p + 1);
      end
    end
    step = 1;
    for (int k = 0; k < 3; k++) tick();
    step = 0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({addr, cnt} !== {32'h10, 32'd4}) begin
      errors++;
      $display("FAIL step_held: got pc=%h cnt=%0d want pc=10 cnt=4", addr, cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1; halt_addr = 32'h10;
    go(1'b0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({addr, halted} !== {32'h10, 1'b0}) begin
      errors++;
      $display("FAIL pre_halt: got pc=%h h=%b want pc=10 h=0", addr, halted);
    end
    tick();
    checks++;
    if ({addr, instr, ifpp4, valid, halted, en, cnt} !== {32'h14, 32'hFFFF_FFFF, 32'h14, 1'b1, 1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL halt_capture: got pc=%h ins=%h pp4=%h v=%b h=%b en=%b cnt=%0d want 14 ffffffff 14 1 1 0 5",
               addr, instr, ifpp4, valid, halted, en, cnt);
    end
    tick();
    checks++;
    if ({addr, instr, ifpp4, valid, halted, cnt} !== {32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5}) begin
      errors++;
      $display("FAIL halt_bubble: got pc=%h ins=%h pp4=%h v=%b h=%b cnt=%0d want 14 0 0 0 1 5",
               addr, instr, ifpp4, valid, halted, cnt);
    end
    start = 1; step = 1; stall = 0; flush = 1;
    for (int i = 0; i < 3; i++) tick();
    start = 0; step = 0; flush = 0;
    tick();
    checks++;
    if ({addr, valid, halted, en, cnt} !== {32'h14, 1'b0, 1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL halt_frozen: got pc=%h v=%b h=%b en=%b cnt=%0d want 14 0 1 0 5", addr, valid, halted, en, cnt);
    end
  endtask

  task automatic test_random();
    logic s, f, o;
    logic [31:0] v;
    do_reset();
    xmask = $urandom & 32'h7FFF_EFFF;
    go(1'b0);
    for (int i = 0; i < 200; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 4) == 0);
      o = 1'($urandom_range(0, 1));
      v = 32'($urandom_range(0, 255)) << 2;
      cyc(s, f, o, v);
      checks++;
      if ({addr, instr, ifpp4, valid, cnt} !== {m_pc, m_instr, m_pp4, m_valid, m_cnt}) begin
        errors++;
        $display("FAIL random[%0d] s=%b f=%b: got pc=%h ins=%h pp4=%h v=%b cnt=%0d want pc=%h ins=%h pp4=%h v=%b cnt=%0d",
                 i, s, f, addr, instr, ifpp4, valid, cnt, m_pc, m_instr, m_pp4, m_valid, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if ({w_addr, w_pp4} !== {32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_plus4: got pc=%h pp4=%h want fffffffc 00000000", w_addr, w_pp4);
    end
    w_start = 1; tick();
    w_start = 0; tick();
    checks++;
    if ({w_addr, w_instr, w_ifpp4, w_valid, w_cnt, w_en, w_halted} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_advance: got pc=%h ins=%h pp4=%h v=%b cnt=%0d en=%b h=%b want 0 fffffffc 0 1 1 1 0",
               w_addr, w_instr, w_ifpp4, w_valid, w_cnt, w_en, w_halted);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run();
    test_async_reset();
    test_stall_flush();
    test_step();
    test_halt();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
